// File: rtl/debug_frame_tx_pkg.sv
// Shared definitions for the debug UART frame path: FSM state encoding and
// the frame start byte, which the receive side also uses.
package debug_frame_tx_pkg;

  // State encoding, kept as plain constants so other blocks can decode it
  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_SEND = 2'd1;
  localparam logic [1:0] STATE_WAIT = 2'd2;
  localparam logic [1:0] STATE_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = STATE_IDLE,
    SEND = STATE_SEND,
    WAIT = STATE_WAIT,
    DONE = STATE_DONE
  } state_e;

  // Frame start byte shared by transmit and receive paths
  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  // Integer ceiling division, used to size the payload in whole bytes
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/debug_frame_tx.sv
// Debug frame serializer: captures a wide snapshot and sends it to uart_tx
// as HEADER, payload bytes LSB-first, then the XOR checksum of the payload.
module debug_frame_tx
  import debug_frame_tx_pkg::*;
#(
  parameter int                 NB_DATA  = 8,
  parameter int                 NB_FRAME = 144,
  parameter logic [NB_DATA-1:0] HEADER   = NB_DATA'(HEADER_BYTE)
) (
  input  logic                clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [NB_FRAME-1:0] i_frame,
  input  logic                i_txDone,
  output logic                o_tx_start,
  output logic [NB_DATA-1:0]  o_data,
  output logic                o_busy,
  output logic                o_done
);

  // Payload rounded up to whole bytes; odd widths are zero-padded at the top
  localparam int NB_BYTES = ceil_div(NB_FRAME, NB_DATA);
  localparam int NB_SNAP  = NB_BYTES * NB_DATA;
  // Counter covers HEADER (0), payload (1..NB_BYTES) and CHK (NB_BYTES+1)
  localparam int CNT_W    = $clog2(NB_BYTES + 2);

  localparam logic [CNT_W-1:0] LAST_PAYLOAD_IDX = CNT_W'(NB_BYTES);
  localparam logic [CNT_W-1:0] CHK_IDX          = CNT_W'(NB_BYTES + 1);

  state_e             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [NB_DATA-1:0] chk_reg;
  logic [NB_SNAP-1:0] snap_reg;
  logic               tx_start_reg;
  logic [NB_DATA-1:0] data_reg;
  logic               busy_reg;
  logic               done_reg;

  logic [NB_SNAP-1:0] snap_next;
  logic [NB_DATA-1:0] cur_byte;
  logic               cur_is_payload;
  logic [NB_DATA-1:0] payload_byte [NB_BYTES];

  // Slice the snapshot into payload bytes, byte 0 in the LSBs
  generate
    for (genvar gi = 0; gi < NB_BYTES; gi++) begin : g_payload
      assign payload_byte[gi] = snap_reg[gi*NB_DATA +: NB_DATA];
    end
  endgenerate

  // Zero-extend the incoming snapshot to a whole number of bytes
  always_comb begin
    snap_next                 = '0;
    snap_next[NB_FRAME-1:0]   = i_frame;
  end

  // Select the byte addressed by the counter: header, payload or checksum
  always_comb begin
    cur_byte       = chk_reg;
    cur_is_payload = 1'b0;
    if (cnt_reg == '0) begin
      cur_byte = HEADER;
    end else if (cnt_reg <= LAST_PAYLOAD_IDX) begin
      cur_is_payload = 1'b1;
      for (int k = 0; k < NB_BYTES; k++) begin
        if (cnt_reg == CNT_W'(k + 1)) begin
          cur_byte = payload_byte[k];
        end
      end
    end
  end

  // Frame FSM with registered handshake outputs
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      chk_reg      <= '0;
      snap_reg     <= '0;
      tx_start_reg <= 1'b0;
      data_reg     <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      tx_start_reg <= 1'b0;
      done_reg     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            snap_reg  <= snap_next;
            chk_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= SEND;
          end
        end
        SEND: begin
          // Byte is presented with its start pulse and held until acknowledged
          tx_start_reg <= 1'b1;
          data_reg     <= cur_byte;
          if (cur_is_payload) begin
            chk_reg <= chk_reg ^ cur_byte;
          end
          state_reg <= WAIT;
        end
        WAIT: begin
          if (i_txDone) begin
            if (cnt_reg == CHK_IDX) begin
              state_reg <= DONE;
            end else begin
              cnt_reg   <= cnt_reg + CNT_W'(1);
              state_reg <= SEND;
            end
          end
        end
        DONE: begin
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign o_tx_start = tx_start_reg;
  assign o_data     = data_reg;
  assign o_busy     = busy_reg;
  assign o_done     = done_reg;

endmodule

// File: tb/tb_debug_frame_tx.sv
// Bench for debug_frame_tx: table of frames (incrementing, zero, random) run
// through the default-width DUT with a fixed-latency uart_tx responder, each
// compared against a byte-list model; plus a 12-bit instance for padding.
module tb_debug_frame_tx;

  typedef logic [7:0] byteq_t[$];

  typedef struct {
    logic [143:0] frame;
    int           mode;       // 0 plain, 1 restart+frame change, 2 spurious done, 3 reset mid-frame, 4 start in DONE
    int           exp_count;  // tx_start pulses expected
    logic [7:0]   exp_chk;    // last byte expected (only for completed frames)
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [143:0] frame = '0;
  logic         tx_done;
  logic         tx_start;
  logic [7:0]   data;
  logic         busy;
  logic         done;

  logic         ack_pulse = 1'b0;
  logic         tx_spur = 1'b0;
  int           ack_cd = 0;

  logic         start12 = 1'b0;
  logic [11:0]  frame12 = '0;
  logic         tx_done12 = 1'b0;
  logic         tx_start12;
  logic [7:0]   data12;
  logic         busy12;
  logic         done12;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_tx = -1;
  int done_cnt = 0;
  int busy_bad = 0;
  byteq_t got_q;
  int gap_q[$];

  assign tx_done = ack_pulse | tx_spur;

  always #5 clk = ~clk;

  debug_frame_tx dut (
    .clk        (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_frame    (frame),
    .i_txDone   (tx_done),
    .o_tx_start (tx_start),
    .o_data     (data),
    .o_busy     (busy),
    .o_done     (done)
  );

  debug_frame_tx #(.NB_FRAME(12)) dut_small (
    .clk        (clk),
    .i_rst_n    (rst_n),
    .i_start    (start12),
    .i_frame    (frame12),
    .i_txDone   (tx_done12),
    .o_tx_start (tx_start12),
    .o_data     (data12),
    .o_busy     (busy12),
    .o_done     (done12)
  );

  // uart_tx stand-in: acknowledge each start pulse 20 cycles later
  always @(negedge clk) begin
    ack_pulse = 1'b0;
    if (!rst_n) begin
      ack_cd = 0;
    end else if (tx_start) begin
      ack_cd = 20;
    end else if (ack_cd > 0) begin
      ack_cd = ack_cd - 1;
      if (ack_cd == 0) ack_pulse = 1'b1;
    end
  end

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  // Reference: header, payload bytes LSB-first, XOR of the payload bytes
  function automatic byteq_t model(input logic [143:0] f);
    byteq_t q;
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    q.push_back(8'hA5);
    for (int k = 0; k < 18; k++) begin
      b = f[8*k +: 8];
      q.push_back(b);
      x = x ^ b;
    end
    q.push_back(x);
    return q;
  endfunction

  // Advance one cycle and record what the DUT emitted
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (tx_start) begin
      if (last_tx >= 0) gap_q.push_back(cyc - last_tx);
      last_tx = cyc;
      got_q.push_back(data);
    end
    if (done) begin
      done_cnt++;
      if (busy) busy_bad++;
    end
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    byteq_t exp_q;
    int     t;
    int     gap_bad;
    int     byte_bad;
    int     n;
    bit     restarted;
    bit     aborted;
    exp_q = model(v.frame);
    got_q.delete();
    gap_q.delete();
    done_cnt = 0;
    busy_bad = 0;
    last_tx = -1;
    restarted = 0;
    aborted = 0;
    frame = v.frame;
    if (v.mode == 2) begin
      tx_spur = 1'b1;
      tick();
      tx_spur = 1'b0;
      tick();
      tick();
      chk("idle_spurious_busy", busy, 0);
      chk("idle_spurious_starts", got_q.size(), 0);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("latency_busy", busy, 1);
    chk("latency_not_early", tx_start, 0);
    if (v.mode == 2) tx_spur = 1'b1;
    tick();
    tx_spur = 1'b0;
    chk("latency_tx_start", tx_start, 1);
    t = 0;
    while (done_cnt == 0 && t < 3000) begin
      start = 1'b0;
      tx_spur = 1'b0;
      if (v.mode == 1 && got_q.size() == 6 && !restarted) begin
        start = 1'b1;
        frame = ~v.frame;
        restarted = 1;
      end
      if (v.mode == 4 && got_q.size() == exp_q.size() && cyc - last_tx == 21) start = 1'b1;
      if (v.mode == 2 && last_tx >= 0 && cyc - last_tx == 21) tx_spur = 1'b1;
      if (v.mode == 3 && got_q.size() == 9) begin
        #2 rst_n = 1'b0;
        #1;
        chk("reset_tx_start", tx_start, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_data", data, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("reset_idle_busy", busy, 0);
        aborted = 1;
        break;
      end
      tick();
      t++;
    end
    start = 1'b0;
    tx_spur = 1'b0;
    if (!aborted) begin
      chk("frame_timeout", (t >= 3000) ? 1 : 0, 0);
      for (int i = 0; i < 40; i++) tick();
      chk("done_pulses", done_cnt, 1);
      chk("done_with_busy_high", busy_bad, 0);
      chk("busy_after_done", busy, 0);
    end
    chk("byte_count", got_q.size(), v.exp_count);
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    byte_bad = 0;
    for (int i = 0; i < n; i++) begin
      if (got_q[i] !== exp_q[i]) begin
        byte_bad++;
        $display("FAIL byte[%0d] frame %0d: got %02h expected %02h", i, idx, got_q[i], exp_q[i]);
      end
    end
    chk("byte_values", byte_bad, 0);
    gap_bad = 0;
    foreach (gap_q[i]) if (gap_q[i] != 22) gap_bad++;
    chk("byte_spacing", gap_bad, 0);
    if (!aborted && got_q.size() > 0) chk("checksum_byte", got_q[got_q.size()-1], v.exp_chk);
    $display("frame %0d mode %0d: %0d bytes sent, last %02h", idx, v.mode, got_q.size(),
             (got_q.size() > 0) ? got_q[got_q.size()-1] : 8'h00);
  endtask

  initial begin
    vec_t         vecs[8];
    logic [143:0] inc_f;
    logic [143:0] rnd_f;
    byteq_t       tmp_q;
    logic [7:0]   exp12[4];
    byteq_t       got12;
    int           cd;
    int           t;
    int           done12_cnt;

    for (int k = 0; k < 18; k++) inc_f[8*k +: 8] = 8'(k + 1);
    vecs[0] = '{frame: inc_f,  mode: 0, exp_count: 20, exp_chk: 8'h13};
    vecs[1] = '{frame: '0,     mode: 0, exp_count: 20, exp_chk: 8'h00};
    vecs[2] = '{frame: inc_f,  mode: 1, exp_count: 20, exp_chk: 8'h13};
    vecs[3] = '{frame: inc_f,  mode: 2, exp_count: 20, exp_chk: 8'h13};
    vecs[4] = '{frame: inc_f,  mode: 3, exp_count: 9,  exp_chk: 8'h00};
    for (int r = 5; r < 8; r++) begin
      for (int w = 0; w < 5; w++) rnd_f[32*w +: 16] = 16'($urandom);
      for (int w = 0; w < 144; w += 16) rnd_f[w +: 16] = 16'($urandom);
      tmp_q = model(rnd_f);
      vecs[r] = '{frame: rnd_f, mode: (r == 6) ? 4 : 0, exp_count: 20, exp_chk: tmp_q[19]};
    end

    rst_n = 1'b0;
    tick();
    tick();
    chk("reset_state_tx_start", tx_start, 0);
    chk("reset_state_data", data, 0);
    chk("reset_state_busy", busy, 0);
    chk("reset_state_done", done, 0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) run_frame(vecs[i], i);

    // Narrow instance: 12-bit payload padded to two bytes
    exp12[0] = 8'hA5;
    exp12[1] = 8'hBC;
    exp12[2] = 8'h0A;
    exp12[3] = 8'hB6;
    frame12 = 12'hABC;
    start12 = 1'b1;
    tick();
    start12 = 1'b0;
    cd = 0;
    t = 0;
    done12_cnt = 0;
    while (done12_cnt == 0 && t < 500) begin
      tick();
      t++;
      tx_done12 = 1'b0;
      if (done12) done12_cnt++;
      if (tx_start12) begin
        got12.push_back(data12);
        cd = 3;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) tx_done12 = 1'b1;
      end
    end
    tx_done12 = 1'b0;
    chk("small_timeout", (t >= 500) ? 1 : 0, 0);
    chk("small_byte_count", got12.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got12.size()) chk($sformatf("small_byte%0d", i), got12[i], exp12[i]);
    end
    chk("small_busy_after", busy12, 0);
    $display("frame small: %0d bytes sent", got12.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debug_frame_tx.md
Name: debug_frame_tx

Overview:
- Transmit-side serializer for the debug UART link.
- Takes a wide snapshot of pipeline debug state, packs it into a byte frame (header, payload LSB-first, XOR checksum), and feeds it one byte at a time to the UART transmitter over its start/done handshake.
- Sits between the pipeline debug outputs and uart_tx. It is the counterpart of the receive path that assembles UART bytes into 32-bit instruction words.

Parameters:
- NB_DATA, 8, UART byte width.
- NB_FRAME, 144, payload snapshot width in bits. Any value of 1 or more is legal; non-multiples of 8 are zero-padded in the MSBs.
- HEADER, 8'hA5, frame start byte.

Ports:
- clk  in  1  system clock.
- i_rst_n  in  1  reset.
- i_start  in  1  single-cycle request to capture i_frame and send a frame.
- i_frame  in  NB_FRAME  debug snapshot.
- i_txDone  in  1  uart_tx byte-complete pulse.
- o_tx_start  out  1  single-cycle pulse to uart_tx.
- o_data  out  NB_DATA  byte to uart_tx.
- o_busy  out  1  frame in progress.
- o_done  out  1  single-cycle pulse after the last byte completes.

Interface (already decided): one clock, clk; reset i_rst_n is asynchronous and active-low.

Behaviour:
- Derived constant: NB_BYTES = ceil(NB_FRAME/8), which is 18 at the default width.
- Frame on the wire: HEADER, then payload bytes 0..NB_BYTES-1 with byte k = snapshot[8k+7:8k], then CHK.
  - CHK = XOR of all payload bytes. HEADER is excluded.
- Reset values: o_tx_start=0, o_data=0, o_busy=0, o_done=0, state=IDLE, byte counter=0, checksum=0, snapshot=0.
- State machine: IDLE -> SEND -> WAIT -> (SEND | DONE) -> IDLE.
- IDLE:
  - When i_start=1, latch i_frame into the snapshot, clear the checksum, set the counter to 0, select HEADER, go to SEND, set o_busy=1 at the next edge.
  - When i_start=0, stay in IDLE.
- SEND (one cycle):
  - o_tx_start=1 for exactly this cycle.
  - o_data carries the current byte and stays stable until the matching i_txDone.
  - Next state is WAIT.
- WAIT:
  - Hold until i_txDone=1, then advance the byte index.
  - Each payload byte is XORed into the checksum when it enters SEND.
  - If the byte just finished was CHK, go to DONE; otherwise go to SEND with the next byte.
- DONE (one cycle):
  - o_done=1 and o_busy=0 at the same edge, then return to IDLE.
  - o_data holds CHK until the next frame starts.
- Latency: an i_start sampled at edge 0 puts o_tx_start high in the cycle after edge 1. Back-to-back bytes are separated by exactly one cycle after i_txDone.
- Boundary conditions:
  - i_start while o_busy=1 is ignored: no re-latch and no restart.
  - i_start in the DONE cycle is ignored; it is accepted only in IDLE.
  - i_txDone outside WAIT is ignored, including in IDLE and SEND.
  - Changes on i_frame after the capture edge do not affect the frame in progress.
  - Asynchronous reset mid-frame returns all outputs to reset values immediately. No partial continuation; the next i_start sends a fresh HEADER.
  - The byte counter never wraps within a frame. Its width is clog2(NB_BYTES+2).

Decomposition:
- Shared package: the state encoding (IDLE, SEND, WAIT, DONE) as localparams, plus the HEADER constant, so the receive-side interface uses the same value.
- NB_BYTES and the counter width are computed in-module.
- No sub-module. Byte selection is an indexed part-select of the snapshot; checksum and FSM are inline.

Test Plan:
- Default width, i_frame bytes 0x01..0x12 (byte0=0x01), bench answers each o_tx_start with i_txDone 20 cycles later -> o_data sequence A5,01,02,…,12,13 (20 bytes). o_done pulses once, o_busy is low afterwards.
- All-zero frame -> A5, then 18 × 00, then CHK 00. Exactly 20 o_tx_start pulses.
- i_start pulsed again while sending byte 5, and i_frame changed after capture -> output identical to the first run, with no extra header.
- Spurious i_txDone in IDLE and during a SEND cycle -> no state change. Byte count stays 20.
- Reset asserted during payload byte 7 -> o_tx_start, o_busy and o_done all 0 at once. The next i_start yields A5 first, with the checksum recomputed from scratch.
- NB_FRAME=12, i_frame=12'hABC -> bytes A5, BC, 0A, then CHK B6.
